// File: rtl/control_pkg.sv
// Shared definitions for the accumulator machine control unit:
// default widths, opcode values and the datapath mux/ALU encodings.
package control_pkg;

  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OPC_W   = DEF_INSTR_W - DEF_ADDR_W;

  typedef enum logic [4:0] {
    OP_HLT  = 5'b00000,
    OP_STO  = 5'b00001,
    OP_LD   = 5'b00010,
    OP_LDI  = 5'b00011,
    OP_ADD  = 5'b00100,
    OP_ADDI = 5'b00101,
    OP_SUB  = 5'b00110,
    OP_SUBI = 5'b00111
  } opcode_t;

  typedef enum logic [1:0] {
    SEL_RAM = 2'b00,
    SEL_IMM = 2'b01,
    SEL_ALU = 2'b10
  } sela_t;

  localparam logic SELB_RAM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode decoder; any opcode outside the defined
// set falls through to the all-zero default and behaves as a NOP.
module control_decoder
  import control_pkg::*;
#(
  parameter int OPC_W = DEF_OPC_W
) (
  input  logic [OPC_W-1:0] opcode,
  output logic [1:0]       SelA,
  output logic             SelB,
  output logic             WrAcc,
  output logic             Op,
  output logic             WrRam,
  output logic             RdRam
);

  always_comb begin
    SelA  = SEL_RAM;
    SelB  = SELB_RAM;
    WrAcc = 1'b0;
    Op    = ALU_ADD;
    WrRam = 1'b0;
    RdRam = 1'b0;
    case (opcode)
      OPC_W'(OP_HLT): begin
      end
      OPC_W'(OP_STO): begin
        WrRam = 1'b1;
      end
      OPC_W'(OP_LD): begin
        SelA  = SEL_RAM;
        WrAcc = 1'b1;
        RdRam = 1'b1;
      end
      OPC_W'(OP_LDI): begin
        SelA  = SEL_IMM;
        WrAcc = 1'b1;
      end
      OPC_W'(OP_ADD): begin
        SelA  = SEL_ALU;
        SelB  = SELB_RAM;
        Op    = ALU_ADD;
        WrAcc = 1'b1;
        RdRam = 1'b1;
      end
      OPC_W'(OP_ADDI): begin
        SelA  = SEL_ALU;
        SelB  = SELB_IMM;
        Op    = ALU_ADD;
        WrAcc = 1'b1;
      end
      OPC_W'(OP_SUB): begin
        SelA  = SEL_ALU;
        SelB  = SELB_RAM;
        Op    = ALU_SUB;
        WrAcc = 1'b1;
        RdRam = 1'b1;
      end
      OPC_W'(OP_SUBI): begin
        SelA  = SEL_ALU;
        SelB  = SELB_IMM;
        Op    = ALU_SUB;
        WrAcc = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/control.sv
// Control unit top: program counter, instruction split into opcode and
// operand, and reset gating of the state-changing enables.
module control
  import control_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  Addr,
  output logic [1:0]         SelA,
  output logic               SelB,
  output logic               WrAcc,
  output logic               Op,
  output logic               WrRam,
  output logic               RdRam,
  output logic [ADDR_W-1:0]  Operand
);

  localparam int OPC_W = INSTR_W - ADDR_W;

  logic [OPC_W-1:0]  opcode;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              decWrAcc;
  logic              decWrRam;
  logic              decRdRam;

  assign opcode  = Instruction[INSTR_W-1:ADDR_W];
  assign Operand = Instruction[ADDR_W-1:0];
  assign halted  = (opcode == OPC_W'(OP_HLT));

  control_decoder #(
    .OPC_W (OPC_W)
  ) u_decoder (
    .opcode (opcode),
    .SelA   (SelA),
    .SelB   (SelB),
    .WrAcc  (decWrAcc),
    .Op     (Op),
    .WrRam  (decWrRam),
    .RdRam  (decRdRam)
  );

  // Reset wins over both hold and increment, so a halted machine restarts
  // from address 0; the counter wraps naturally at the top of memory.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc <= '0;
    end else if (!halted) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  assign Addr = pc;

  // Only the enables that change machine state are suppressed during reset.
  assign WrAcc = decWrAcc & ~Reset;
  assign WrRam = decWrRam & ~Reset;
  assign RdRam = decRdRam & ~Reset;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: a memory-less reference model of the
// program counter and the opcode control table, driven with random programs.
module tb_control;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] Instruction;
  logic [10:0] Addr;
  logic [1:0]  SelA;
  logic        SelB;
  logic        WrAcc;
  logic        Op;
  logic        WrRam;
  logic        RdRam;
  logic [10:0] Operand;

  logic [6:0]  ctlObs;
  int          checks = 0;
  int          passes = 0;
  int          expPc  = 0;
  logic [15:0] prog [8];

  control dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Instruction (Instruction),
    .Addr        (Addr),
    .SelA        (SelA),
    .SelB        (SelB),
    .WrAcc       (WrAcc),
    .Op          (Op),
    .WrRam       (WrRam),
    .RdRam       (RdRam),
    .Operand     (Operand)
  );

  always #5 Clk = ~Clk;

  assign ctlObs = {SelA, SelB, WrAcc, Op, WrRam, RdRam};

  // Expected {SelA, SelB, WrAcc, Op, WrRam, RdRam} straight from the opcode table.
  function automatic logic [6:0] expCtl(input logic [4:0] opc, input logic rst);
    logic [1:0] a;
    logic       b, w, o, s, r;
    {a, b, w, o, s, r} = '0;
    case (opc)
      5'd1: s = 1'b1;
      5'd2: begin a = 2'b00; w = 1'b1; r = 1'b1; end
      5'd3: begin a = 2'b01; w = 1'b1; end
      5'd4: begin a = 2'b10; w = 1'b1; r = 1'b1; end
      5'd5: begin a = 2'b10; b = 1'b1; w = 1'b1; end
      5'd6: begin a = 2'b10; o = 1'b1; w = 1'b1; r = 1'b1; end
      5'd7: begin a = 2'b10; b = 1'b1; o = 1'b1; w = 1'b1; end
      default: ;
    endcase
    if (rst) begin
      w = 1'b0;
      s = 1'b0;
      r = 1'b0;
    end
    return {a, b, w, o, s, r};
  endfunction

  function automatic logic [15:0] randNonHlt();
    logic [4:0]  opc;
    logic [10:0] opd;
    opc = 5'($urandom_range(1, 31));
    opd = 11'($urandom);
    return {opc, opd};
  endfunction

  task automatic applyStimulus(input logic rst, input logic [15:0] instr);
    @(negedge Clk);
    Reset       = rst;
    Instruction = instr;
    #1;
  endtask

  task automatic advanceModel();
    if (Reset) expPc = 0;
    else if (Instruction[15:11] != 5'd0) expPc = (expPc + 1) % 2048;
  endtask

  task automatic test_reset();
    Reset       = 1'b1;
    Instruction = 16'h2001;
    @(negedge Clk);
    #1;
    checks++;
    if (Addr !== 11'd0) $display("FAIL reset_addr: got %0d want 0", Addr);
    else passes++;
    checks++;
    if ({WrAcc, RdRam, WrRam} !== 3'b000) $display("FAIL reset_gating: got %b want 000", {WrAcc, RdRam, WrRam});
    else passes++;
    checks++;
    if ({SelA, SelB, Op} !== 4'b1000) $display("FAIL reset_decode: got %b want 1000", {SelA, SelB, Op});
    else passes++;
    advanceModel();
    applyStimulus(1'b0, 16'h2001);
    checks++;
    if ({ctlObs, Operand} !== {7'b1001001, 11'd1}) $display("FAIL reset_release: got %b/%0d want 1001001/1", ctlObs, Operand);
    else passes++;
    advanceModel();
    applyStimulus(1'b0, 16'h2001);
    checks++;
    if (Addr !== 11'd1) $display("FAIL first_increment: got %0d want 1", Addr);
    else passes++;
    advanceModel();
  endtask

  task automatic test_program();
    applyStimulus(1'b1, prog[0]);
    advanceModel();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, prog[expPc]);
      checks++;
      if (Addr !== 11'(k)) $display("FAIL prog_addr: got %0d want %0d", Addr, k);
      else passes++;
      checks++;
      if ({ctlObs, Operand} !== {expCtl(prog[k][15:11], 1'b0), 11'(k + 1)})
        $display("FAIL prog_ctl step %0d: got %b/%0d want %b/%0d", k, ctlObs, Operand, expCtl(prog[k][15:11], 1'b0), k + 1);
      else passes++;
      advanceModel();
    end
  endtask

  task automatic test_halt();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 16'h0008);
      checks++;
      if ({Addr, ctlObs, Operand} !== {11'd7, 7'd0, 11'd8})
        $display("FAIL halt_hold: got addr %0d ctl %b opd %0d want 7/0000000/8", Addr, ctlObs, Operand);
      else passes++;
      advanceModel();
    end
  endtask

  task automatic test_halt_release();
    applyStimulus(1'b1, 16'h0008);
    checks++;
    if ({Addr, ctlObs} !== {11'd7, 7'd0}) $display("FAIL halt_reset: got %0d/%b want 7/0000000", Addr, ctlObs);
    else passes++;
    advanceModel();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, prog[k]);
      checks++;
      if (Addr !== 11'(k)) $display("FAIL halt_resume: got %0d want %0d", Addr, k);
      else passes++;
      advanceModel();
    end
  endtask

  task automatic test_undefined();
    int pcBefore;
    applyStimulus(1'b0, 16'hF809);
    checks++;
    if ({ctlObs, Operand} !== {7'd0, 11'd9}) $display("FAIL undef_ctl: got %b/%0d want 0000000/9", ctlObs, Operand);
    else passes++;
    pcBefore = expPc;
    advanceModel();
    for (int k = 0; k < 20; k++) begin
      logic [15:0] instr;
      instr = {5'($urandom_range(8, 31)), 11'($urandom)};
      applyStimulus(1'b0, instr);
      checks++;
      if ({Addr, ctlObs, Operand} !== {11'((pcBefore + 1 + k) % 2048), 7'd0, instr[10:0]})
        $display("FAIL undef_step: got %0d/%b/%0d want %0d/0000000/%0d", Addr, ctlObs, Operand, (pcBefore + 1 + k) % 2048, instr[10:0]);
      else passes++;
      advanceModel();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] instr;
    applyStimulus(1'b1, randNonHlt());
    advanceModel();
    for (int k = 0; k < 2047; k++) begin
      instr = randNonHlt();
      applyStimulus(1'b0, instr);
      checks++;
      if ({Addr, ctlObs, Operand} !== {11'(expPc), expCtl(instr[15:11], 1'b0), instr[10:0]})
        $display("FAIL wrap_walk: got %0d/%b want %0d/%b", Addr, ctlObs, expPc, expCtl(instr[15:11], 1'b0));
      else passes++;
      advanceModel();
    end
    applyStimulus(1'b0, randNonHlt());
    checks++;
    if (Addr !== 11'd2047) $display("FAIL wrap_top: got %0d want 2047", Addr);
    else passes++;
    advanceModel();
    applyStimulus(1'b0, randNonHlt());
    checks++;
    if (Addr !== 11'd0) $display("FAIL wrap_zero: got %0d want 0", Addr);
    else passes++;
    advanceModel();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, randNonHlt());
      advanceModel();
    end
    applyStimulus(1'b1, randNonHlt());
    checks++;
    if (Addr !== 11'd5) $display("FAIL midreset_before: got %0d want 5", Addr);
    else passes++;
    advanceModel();
    applyStimulus(1'b0, randNonHlt());
    checks++;
    if (Addr !== 11'd0) $display("FAIL midreset_after: got %0d want 0", Addr);
    else passes++;
    advanceModel();
  endtask

  task automatic test_random();
    logic [15:0] instr;
    logic        rst;
    for (int k = 0; k < 400; k++) begin
      instr = ($urandom_range(0, 15) == 0) ? {5'd0, 11'($urandom)} : randNonHlt();
      rst   = ($urandom_range(0, 9) == 0);
      applyStimulus(rst, instr);
      checks++;
      if ({Addr, ctlObs, Operand} !== {11'(expPc), expCtl(instr[15:11], rst), instr[10:0]})
        $display("FAIL random step %0d: got %0d/%b/%0d want %0d/%b/%0d", k, Addr, ctlObs, Operand,
                 expPc, expCtl(instr[15:11], rst), instr[10:0]);
      else passes++;
      advanceModel();
    end
  endtask

  initial begin
    prog[0] = {5'd4, 11'd1};
    prog[1] = {5'd1, 11'd2};
    prog[2] = {5'd3, 11'd3};
    prog[3] = {5'd4, 11'd4};
    prog[4] = {5'd7, 11'd5};
    prog[5] = {5'd5, 11'd6};
    prog[6] = {5'd4, 11'd7};
    prog[7] = {5'd0, 11'd8};
    test_reset();
    test_program();
    test_halt();
    test_halt_release();
    test_undefined();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 Parameter ADDR_W, default 11, width of the program counter, Addr and Operand.
REQ-002 Parameter INSTR_W, default 16, instruction width; opcode = Instruction[INSTR_W-1:ADDR_W] (5 bits at default).
REQ-003 Clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 Instruction  input  16  instruction word fetched from program memory at Addr.
REQ-006 Addr  output  11  program counter, driven to program memory.
REQ-007 SelA  output  2  accumulator input mux: 00 data RAM, 01 immediate Operand, 10 ALU result.
REQ-008 SelB  output  1  ALU second-operand mux: 0 data RAM, 1 immediate Operand.
REQ-009 WrAcc  output  1  accumulator write enable.
REQ-010 Op  output  1  ALU operation: 0 add, 1 subtract.
REQ-011 WrRam  output  1  data RAM write enable (RAM[Operand] <= ACC).
REQ-012 RdRam  output  1  data RAM read enable (RAM[Operand]).
REQ-013 Operand  output  11  Instruction[10:0], passed through combinationally.

Function
REQ-014 Decode of SelA, SelB, WrAcc, Op, WrRam, RdRam shall be purely combinational from the opcode; zero latency.
REQ-015 Opcode 00000 HLT: all control outputs 0; PC holds its value.
REQ-016 Opcode 00001 STO: WrRam=1; all other controls 0.
REQ-017 Opcode 00010 LD: SelA=00, WrAcc=1, RdRam=1.
REQ-018 Opcode 00011 LDI: SelA=01, WrAcc=1.
REQ-019 Opcode 00100 ADD: SelA=10, SelB=0, Op=0, WrAcc=1, RdRam=1.
REQ-020 Opcode 00101 ADDI: SelA=10, SelB=1, Op=0, WrAcc=1.
REQ-021 Opcode 00110 SUB: SelA=10, SelB=0, Op=1, WrAcc=1, RdRam=1.
REQ-022 Opcode 00111 SUBI: SelA=10, SelB=1, Op=1, WrAcc=1.
REQ-023 Controls not listed for an opcode shall be 0.
REQ-024 Opcodes 01000-11111 are undefined: decoded as NOP (all controls 0); PC increments.
REQ-025 PC shall increment by 1 on every rising edge when Reset=0 and opcode is not HLT.
REQ-026 PC shall wrap from 2047 to 0 without any flag.
REQ-027 HLT is sticky: PC stays at the HLT address until Reset.
REQ-028 Operand shall equal Instruction[10:0] for every opcode, including HLT and undefined opcodes.

Reset
REQ-029 Reset=1 at a rising edge shall load PC=0, regardless of the current opcode, including HLT.
REQ-030 While Reset=1, WrAcc, WrRam and RdRam shall be forced to 0; SelA, SelB and Op follow decode.
REQ-031 Reset shall take priority over increment and hold; the first increment occurs on the first edge with Reset=0.
REQ-032 Before the first reset, PC is undefined; no initial value is required.

Structure
REQ-033 Shared package control_pkg shall hold the opcode constants (HLT..SUBI), the SelA encodings (SEL_RAM, SEL_IMM, SEL_ALU), the SelB encodings, the Op encodings and the default widths.
REQ-034 Combinational decode shall live in a sub-module control_decoder (opcode in, six control signals out); the top level holds the PC register, the reset gating and the Operand split.

Verification
REQ-035 Reset: pulse Reset=1 for 1 edge with Instruction=16'h2001 -> Addr=0; WrAcc=0 and RdRam=0 during Reset; after release, SelA=10, SelB=0, Op=0, WrAcc=1, RdRam=1, Operand=1.
REQ-036 Program sequencing: memory model returns ADD 1, STO 2, LDI 3, ADD 4, SUBI 5, ADDI 6, ADD 7, HLT 8 at Addr 0..7 -> Addr advances 0..7 one per clock, each cycle's controls match REQ-015..022, Operand equals Addr+1.
REQ-037 Halt: at Addr 7 (HLT, 16'h0008) -> Addr stays at 7 for at least 10 clocks, all controls 0, Operand=8.
REQ-038 Halt release: assert Reset while halted -> Addr=0 on the next edge, and execution resumes.
REQ-039 Undefined opcode: Instruction=16'hF809 -> all controls 0, Operand=9, PC increments.
REQ-040 Wrap: preload PC to 2047 with non-HLT instructions -> next Addr=0; assert Reset mid-program at Addr 5 -> Addr=0 on the same edge.
